// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, FSM state type and address field helpers for the dcache controller
package dcache_pkg;
    localparam int TAG_W         = 23;
    localparam int IDX_W         = 4;
    localparam int LINE_W        = 256;
    localparam int OFFSET_W      = 5;
    localparam int WORD_IDX_W    = 3;
    localparam int TAG_VALID_BIT = 24;
    localparam int TAG_DIRTY_BIT = 23;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, FILL_DONE} state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return TAG_W'(addr >> (IDX_W + OFFSET_W));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return IDX_W'(addr >> OFFSET_W);
    endfunction

    function automatic logic [WORD_IDX_W-1:0] addr_word(input logic [31:0] addr);
        return WORD_IDX_W'(addr >> 2);
    endfunction
endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: selects one 32-bit word of a cache line and builds the line with that word replaced
//   line_i     : source line (word 0 = bits [31:0])
//   word_idx_i : word index within the line
//   data_i     : replacement word
//   word_o     : selected word of line_i
//   line_o     : line_i with the selected word replaced by data_i
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0]     line_i,
    input  logic [WORD_IDX_W-1:0] word_idx_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           word_o,
    output logic [LINE_W-1:0]     line_o
);
    assign word_o = line_i[{word_idx_i, 5'b0} +: 32];

    for (genvar i = 0; i < LINE_W / 32; i++) begin : g_word
        assign line_o[32*i +: 32] = (word_idx_i == WORD_IDX_W'(i)) ? data_i : line_i[32*i +: 32];
    end
endmodule

// File: rtl/dcache_ctrl_fsm.sv
// dcache_ctrl_fsm: 2-way 16-set dcache controller with hit path, write-back/allocate miss FSM and CPU stall
//   clk_i, rst_i          : clock, synchronous active-high reset
//   cpu_*                 : CPU load/store request, load data and stall
//   sram_*                : tag/data SRAM access (index, tag/line write, hit and victim/hit way read-back)
//   mem_*                 : handshaked off-chip line memory (write-back and fill)
//   hit_cnt_o, miss_cnt_o : performance counters, present only when DCACHE_PERF_CNT_EN is defined
module dcache_ctrl_fsm
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [IDX_W-1:0]  sram_addr_o,
    output logic [24:0]       sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    input  logic [24:0]       sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    state_e              state_q, state_d;
    logic [31:0]         wb_addr_q;
    logic [LINE_W-1:0]   wb_data_q, fill_q, merged;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    idx;
    logic                miss, victim_dirty;

    assign tag           = addr_tag(cpu_addr_i);
    assign idx           = addr_idx(cpu_addr_i);
    assign miss          = cpu_req_i & ~sram_hit_i;
    assign victim_dirty  = sram_tag_i[TAG_VALID_BIT] & sram_tag_i[TAG_DIRTY_BIT];
    assign sram_addr_o   = idx;
    assign sram_enable_o = cpu_req_i;

    dcache_word_merge u_merge (
        .line_i     (sram_data_i),
        .word_idx_i (addr_word(cpu_addr_i)),
        .data_i     (cpu_data_i),
        .word_o     (cpu_data_o),
        .line_o     (merged)
    );

    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b1;
        sram_write_o = 1'b0;
        sram_data_o  = merged;
        sram_tag_o   = {2'b11, tag};
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            IDLE: begin
                cpu_stall_o  = miss;
                sram_write_o = cpu_req_i & sram_hit_i & cpu_write_i;
                if (miss) state_d = victim_dirty ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = wb_addr_q;
                mem_data_o   = wb_data_q;
                if (mem_ack_i) state_d = FILL;
            end
            FILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) state_d = FILL_DONE;
            end
            FILL_DONE: begin
                sram_write_o = 1'b1;
                sram_data_o  = fill_q;
                sram_tag_o   = {2'b10, tag};
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Victim is captured on the miss cycle so the write-back stays stable while the SRAM read-back may change.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && miss) begin
            wb_addr_q <= {sram_tag_i[TAG_W-1:0], idx, {OFFSET_W{1'b0}}};
            wb_data_q <= sram_data_i;
        end
        if (state_q == FILL && mem_ack_i) fill_q <= mem_data_i;
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && cpu_req_i && sram_hit_i) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// tb_dcache_ctrl_fsm: randomized self-checking bench with SRAM/memory emulation and a transaction-level cache model
module tb_dcache_ctrl_fsm;
    logic clk = 1'b0;
    logic rst;
    logic cpu_req_i, cpu_write_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic cpu_stall_o;
    logic [3:0] sram_addr_o;
    logic [24:0] sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic sram_enable_o, sram_write_o, sram_hit_i;
    logic mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0] mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    always #5 clk = ~clk;

    dcache_ctrl_fsm dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference memory image as the CPU sees it, and the backing memory behind the controller.
    bit [31:0] ref_word[bit [31:0]];
    bit [31:0] mem_word[bit [31:0]];

    function automatic bit [31:0] pat(input bit [31:0] wa);
        return wa * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        bit [31:0] wa = a >> 2;
        return ref_word.exists(wa) ? ref_word[wa] : pat(wa);
    endfunction

    function automatic bit [31:0] mem_rd(input bit [31:0] wa);
        return mem_word.exists(wa) ? mem_word[wa] : pat(wa);
    endfunction

    function automatic bit [255:0] ref_line(input bit [31:0] a);
        bit [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_rd({a[31:5], 5'b0} + 32'(w * 4));
        return l;
    endfunction

    // SRAM emulator: 2 ways x 16 sets with LRU victim selection, written by the DUT.
    bit          s_val[16][2], s_dirty[16][2], s_lru[16];
    bit [22:0]   s_tag[16][2];
    bit [255:0]  s_data[16][2];
    logic        s_hw, s_way;

    always_comb begin
        s_hw = 1'b0;
        sram_hit_i = 1'b0;
        for (int w = 0; w < 2; w++)
            if (s_val[cpu_addr_i[8:5]][w] && s_tag[cpu_addr_i[8:5]][w] == cpu_addr_i[31:9]) begin
                sram_hit_i = 1'b1;
                s_hw = w[0];
            end
        s_way = sram_hit_i ? s_hw : s_lru[cpu_addr_i[8:5]];
        sram_tag_i = {s_val[cpu_addr_i[8:5]][s_way], s_dirty[cpu_addr_i[8:5]][s_way], s_tag[cpu_addr_i[8:5]][s_way]};
        sram_data_i = s_data[cpu_addr_i[8:5]][s_way];
    end

    always @(posedge clk) begin
        if (sram_enable_o && (sram_write_o || sram_hit_i)) begin
            s_lru[sram_addr_o] <= ~s_way;
            if (sram_write_o) begin
                s_val[sram_addr_o][s_way]   <= sram_tag_o[24];
                s_dirty[sram_addr_o][s_way] <= sram_tag_o[23];
                s_tag[sram_addr_o][s_way]   <= sram_tag_o[22:0];
                s_data[sram_addr_o][s_way]  <= sram_data_o;
            end
        end
    end

    // Memory responder: acks after a programmed number of request cycles, checks request stability.
    int          dly_wb = 1, dly_fill = 1, r_cnt = 0, n_wb = 0, n_fill = 0;
    bit          force_ack = 1'b0, fill_acked = 1'b0, r_wr;
    logic [31:0] r_addr, last_wb, last_fill;
    logic [255:0] r_data;

    initial begin
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        mem_word[32'h10] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (fill_acked) chk("en_drop_after_ack", mem_enable_o, 1'b0);
            fill_acked = 1'b0;
            if (force_ack) mem_ack_i = 1'b1;
            else if (mem_enable_o && !rst) begin
                if (r_cnt == 0) begin
                    r_addr = mem_addr_o;
                    r_wr = mem_write_o;
                    r_data = mem_data_o;
                end else begin
                    chk("stable_addr", mem_addr_o, r_addr);
                    chk("stable_write", mem_write_o, r_wr);
                    if (r_wr) chk("stable_data", mem_data_o, r_data);
                end
                r_cnt++;
                if (r_cnt >= (mem_write_o ? dly_wb : dly_fill)) begin
                    mem_ack_i = 1'b1;
                    r_cnt = 0;
                    if (mem_write_o) begin
                        chk("wb_data", mem_data_o, ref_line(mem_addr_o));
                        for (int w = 0; w < 8; w++) mem_word[(mem_addr_o >> 2) + 32'(w)] = mem_data_o[32*w +: 32];
                        n_wb++;
                        last_wb = mem_addr_o;
                    end else begin
                        for (int w = 0; w < 8; w++) mem_data_i[32*w +: 32] = mem_rd((mem_addr_o >> 2) + 32'(w));
                        n_fill++;
                        last_fill = mem_addr_o;
                        fill_acked = 1'b1;
                    end
                end
            end else r_cnt = 0;
        end
    end

    // Per-cycle compare process.
    logic [255:0] c_exp, last_st_data;
    logic [24:0]  last_fd_tag, last_st_tag;

    always @(negedge clk) begin
        if (!rst) begin
            chk("sram_addr", sram_addr_o, cpu_addr_i[8:5]);
            chk("sram_en", sram_enable_o, cpu_req_i);
            if (!cpu_req_i) begin
                chk("noreq_stall", cpu_stall_o, 1'b0);
                chk("noreq_sram_wr", sram_write_o, 1'b0);
                chk("noreq_mem_en", mem_enable_o, 1'b0);
            end else if (!cpu_stall_o) begin
                chk("done_hit", sram_hit_i, 1'b1);
                chk("done_mem_en", mem_enable_o, 1'b0);
                chk("done_sram_wr", sram_write_o, cpu_write_i);
                if (cpu_write_i) begin
                    c_exp = sram_data_i;
                    c_exp[32*cpu_addr_i[4:2] +: 32] = cpu_data_i;
                    chk("store_tag", sram_tag_o, {2'b11, cpu_addr_i[31:9]});
                    chk("store_line", sram_data_o, c_exp);
                    last_st_tag = sram_tag_o;
                    last_st_data = sram_data_o;
                end else chk("load_word", cpu_data_o, sram_data_i[32*cpu_addr_i[4:2] +: 32]);
            end else begin
                if (mem_enable_o) chk("req_aligned", mem_addr_o[4:0], 5'd0);
                if (sram_write_o) begin
                    chk("fill_tag", sram_tag_o, {2'b10, cpu_addr_i[31:9]});
                    chk("fill_line", sram_data_o, ref_line(cpu_addr_i));
                    last_fd_tag = sram_tag_o;
                end
                if (!mem_enable_o && !sram_write_o) chk("stall_only_on_miss", sram_hit_i, 1'b0);
            end
        end
    end

    // Transaction-level cache model predicting hit/miss, victim and dirtiness.
    bit         m_val[16][2], m_dirty[16][2], m_lru[16];
    bit [22:0]  m_tag[16][2];
    int         hits_m = 0, misses_m = 0, last_stalls;
    logic [31:0] last_load;

    task automatic perf_chk(input string nm);
        int eh = 0, em = 0;
`ifdef DCACHE_PERF_CNT_EN
        eh = hits_m;
        em = misses_m;
`endif
        chk({nm, "_hits"}, hit_cnt_o, 32'(eh));
        chk({nm, "_misses"}, miss_cnt_o, 32'(em));
    endtask

    task automatic access(input bit [31:0] a, input bit wr, input bit [31:0] d, input int dwb, input int dfl);
        bit [3:0]  idx = a[8:5];
        bit        hit = 1'b0, hw = 1'b0, v, vdirty, done = 1'b0;
        bit [22:0] vtag;
        int        stalls = 0, exp_stall, nwb0 = n_wb, nfl0 = n_fill;
        for (int w = 0; w < 2; w++)
            if (m_val[idx][w] && m_tag[idx][w] == a[31:9]) begin
                hit = 1'b1;
                hw = w[0];
            end
        v = hit ? hw : m_lru[idx];
        vdirty = !hit && m_val[idx][v] && m_dirty[idx][v];
        vtag = m_tag[idx][v];
        exp_stall = hit ? 0 : 2 + dfl + (vdirty ? dwb : 0);
        dly_wb = dwb;
        dly_fill = dfl;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i = a;
        cpu_data_i = d;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!cpu_stall_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        chk("access_completes", done, 1'b1);
        chk("stall_cycles", stalls, exp_stall);
        if (!wr) chk("load_value", cpu_data_o, ref_rd(a));
        last_load = cpu_data_o;
        last_stalls = stalls;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        chk("wb_count", n_wb - nwb0, vdirty);
        chk("fill_count", n_fill - nfl0, !hit);
        if (vdirty) chk("wb_addr", last_wb, {vtag, idx, 5'b0});
        if (!hit) chk("fill_addr", last_fill, {a[31:5], 5'b0});
        if (!hit) begin
            m_val[idx][v] = 1'b1;
            m_tag[idx][v] = a[31:9];
            m_dirty[idx][v] = 1'b0;
            misses_m++;
        end
        if (wr) begin
            m_dirty[idx][v] = 1'b1;
            ref_word[a >> 2] = d;
        end
        m_lru[idx] = ~v;
        hits_m++;
    endtask

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst = 1'b1;
        cpu_req_i = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        ref_word[32'h10] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", cpu_stall_o, 1'b0);
        chk("reset_mem_en", mem_enable_o, 1'b0);
        chk("reset_mem_wr", mem_write_o, 1'b0);
        chk("reset_mem_addr", mem_addr_o, 32'd0);
        perf_chk("reset");

        access(32'h40, 1'b0, 32'd0, 1, 10);
        chk("pin_fill_addr", last_fill, 32'h40);
        chk("pin_load", last_load, 32'hDEADBEEF);
        chk("pin_stalls", last_stalls, 12);
        chk("pin_fd_tag", last_fd_tag, 25'h1000000);

        access(32'h44, 1'b1, 32'h12345678, 1, 1);
        chk("pin_st_stalls", last_stalls, 0);
        chk("pin_st_tag", last_st_tag, 25'h1800000);
        chk("pin_st_w1", last_st_data[63:32], 32'h12345678);
        chk("pin_st_w0", last_st_data[31:0], 32'hDEADBEEF);

        access(32'h440, 1'b0, 32'd0, 1, 3);
        access(32'h240, 1'b0, 32'd0, 25, 25);
        chk("pin_wb_addr", last_wb, 32'h40);
        chk("pin_fill2_addr", last_fill, 32'h240);
        chk("pin_stalls2", last_stalls, 52);
        chk("pin_wb_mem", mem_word[32'h11], 32'h12345678);
        perf_chk("directed");

        dly_fill = 50;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i = 32'h640;
        @(negedge clk);
        chk("rst_miss_stall", cpu_stall_o, 1'b1);
        @(negedge clk);
        chk("rst_fill_en", mem_enable_o, 1'b1);
        chk("rst_fill_addr", mem_addr_o, 32'h640);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_en_drop", mem_enable_o, 1'b0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        hits_m = 0;
        misses_m = 0;
        perf_chk("after_reset");
        force_ack = 1'b1;
        @(posedge clk);
        #2;
        force_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stray_ack_mem_en", mem_enable_o, 1'b0);
        chk("stray_ack_stall", cpu_stall_o, 1'b0);
        access(32'h640, 1'b0, 32'd0, 1, 2);

        for (int i = 0; i < 300; i++) begin
            access({23'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)},
                   1'($urandom_range(0, 1)), $urandom, int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        perf_chk("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
